// File: rtl/pcp_tcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcp_tcm_pkg
//  Description : Shared constants, FSM state type and ones'-complement adder
//                for the PCP TCM stream reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcp_tcm_pkg;

    localparam int TCM_ADDR_W = 13;
    localparam int TCM_DEPTH  = 6144;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pcp_tcm_state_e;

    // 16-bit ones'-complement addition with end-around carry.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage : pcp_tcm_pkg
`default_nettype wire

// File: rtl/pcp_tcm_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pcp_tcm_skid_fifo
//  Description : Synchronous FIFO absorbing TCM read data that is already in
//                flight when the stream sink stalls; flush has priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcp_tcm_skid_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign empty    = (r_count == '0);

endmodule : pcp_tcm_skid_fifo
`default_nettype wire

// File: rtl/pcp_tcm_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : pcp_tcm_stream_reader
//  Description : Reads a contiguous block of TCM words (latency-1 Avalon-MM)
//                and streams them out on Avalon-ST with backpressure.
//                Optional PCP_TCM_RD_CKSUM_EN adds a ones'-complement cksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcp_tcm_stream_reader
    import pcp_tcm_pkg::*;
#(
    parameter int ADDR_W     = TCM_ADDR_W,
    parameter int DEPTH      = TCM_DEPTH,
    parameter int LEN_W      = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic              m_clken,
    input  logic [31:0]       m_readdata,
    output logic [31:0]       st_data,
    output logic              st_valid,
    output logic              st_sop,
    output logic              st_eop,
    input  logic              st_ready
`ifdef PCP_TCM_RD_CKSUM_EN
    ,
    output logic [15:0]       cksum
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    pcp_tcm_state_e    r_state;
    pcp_tcm_state_e    w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic              r_inflight;
    logic              r_infl_sop;
    logic              r_infl_eop;
    logic              r_done;
    logic              r_error;

    logic              w_done_nxt;
    logic              w_error_nxt;
    logic              w_accept;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_pop;
    logic              w_last_pop;
    logic              w_flush;
    logic              w_range_bad;
    logic [LEN_W:0]    w_range_end;
    logic [CNT_W:0]    w_credit;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic [33:0]       w_fifo_head;

    assign w_range_end  = (LEN_W+1)'(base_addr) + (LEN_W+1)'(len_words);
    assign w_range_bad  = w_range_end > (LEN_W+1)'(DEPTH);
    // Words in the FIFO plus the one whose data returns this cycle.
    assign w_credit     = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(r_inflight);
    assign w_issue      = (r_state == ST_RUN) && !abort && (r_issued < r_len)
                          && (w_credit < (CNT_W+1)'(FIFO_DEPTH));
    assign w_last_issue = (r_issued == r_len - 1'b1);
    assign w_pop        = !w_fifo_empty && st_ready;
    assign w_last_pop   = w_pop && w_fifo_head[32];
    assign w_flush      = abort && (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_error_nxt = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (len_words == '0) begin
                        w_done_nxt = 1'b1;
                    end else if (w_range_bad) begin
                        w_done_nxt  = 1'b1;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_issue && w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort || w_last_pop) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_inflight <= 1'b0;
            r_infl_sop <= 1'b0;
            r_infl_eop <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_inflight <= w_issue;
            r_infl_sop <= (r_issued == '0);
            r_infl_eop <= w_last_issue;
            if (w_accept) begin
                r_addr   <= base_addr;
                r_len    <= len_words;
                r_issued <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + 1'b1;
                r_issued <= r_issued + 1'b1;
            end
        end
    end

    pcp_tcm_skid_fifo #(
        .WIDTH (34),
        .DEPTH (FIFO_DEPTH)
    ) u_skid_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (w_flush),
        .push      (r_inflight),
        .push_data ({r_infl_sop, r_infl_eop, m_readdata}),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty)
    );

    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign error        = r_error;
    assign m_address    = r_addr;
    assign m_chipselect = w_issue;
    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;
    assign m_clken      = 1'b1;
    assign st_valid     = !w_fifo_empty;
    assign st_data      = w_fifo_head[31:0];
    assign st_eop       = !w_fifo_empty && w_fifo_head[32];
    assign st_sop       = !w_fifo_empty && w_fifo_head[33];

`ifdef PCP_TCM_RD_CKSUM_EN
    logic [15:0] r_cksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cksum <= '0;
        end else if (w_accept) begin
            r_cksum <= '0;
        end else if (w_pop) begin
            r_cksum <= ones_add(ones_add(r_cksum, w_fifo_head[31:16]), w_fifo_head[15:0]);
        end
    end

    assign cksum = r_cksum;
`else
    // Checksum datapath not built.
`endif

endmodule : pcp_tcm_stream_reader
`default_nettype wire

// File: tb/tb_pcp_tcm_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcp_tcm_stream_reader
//  Description : Self-checking bench for pcp_tcm_stream_reader with a TCM
//                memory model and a word-level stream scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcp_tcm_stream_reader;

    localparam int MEMD = 6144;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort;
    logic [12:0] base_addr;
    logic [13:0] len_words;
    logic        busy, done, error;
    logic [12:0] m_address;
    logic        m_chipselect, m_write, m_clken;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata;
    logic [31:0] st_data;
    logic        st_valid, st_sop, st_eop;
    logic        st_ready;
`ifdef PCP_TCM_RD_CKSUM_EN
    logic [15:0] cksum;
`endif

    pcp_tcm_stream_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .len_words    (len_words),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata),
        .st_data      (st_data),
        .st_valid     (st_valid),
        .st_sop       (st_sop),
        .st_eop       (st_eop),
        .st_ready     (st_ready)
`ifdef PCP_TCM_RD_CKSUM_EN
        ,
        .cksum        (cksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // TCM model: fixed read latency of one clock.
    logic [31:0] mem [MEMD];
    always @(posedge clk) begin
        if (m_chipselect) m_readdata <= (int'(m_address) < MEMD) ? mem[m_address] : 32'h0;
    end

    // Ready pattern: 0 always, 1 one-in-three, 2 random, 3 never.
    int rmode = 0;
    int rc    = 0;
    always @(posedge clk) begin
        #1;
        rc++;
        case (rmode)
            0:       st_ready = 1'b1;
            1:       st_ready = (rc % 3 == 0);
            2:       st_ready = 1'($urandom_range(0, 1));
            default: st_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard state
    int      cyc = 0;
    int      tr_base, tr_len;
    int      mon_reads, mon_beats, done_cnt;
    bit      busy_seen, done_err;
    int      start_cyc, done_cyc, first_pop, last_pop, first_cs, last_cs;
    longint  model_sum;
    logic [15:0] done_ck;

    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (m_chipselect) begin
                if (mon_reads == 0) first_cs = cyc;
                last_cs = cyc;
                check("rd_addr", 32'(m_address), 32'((tr_base + mon_reads) % 8192));
                mon_reads++;
            end
            if (start && !busy) start_cyc = cyc;
            if (st_valid && st_ready) begin
                logic [31:0] exp_w;
                exp_w = (mon_beats < tr_len) ? mem[tr_base + mon_beats] : 32'hDEADBEEF;
                check("st_data", st_data, exp_w);
                check("st_sop", 32'(st_sop), 32'(mon_beats == 0));
                check("st_eop", 32'(st_eop), 32'(mon_beats == tr_len - 1));
                if (mon_beats == 0) first_pop = cyc;
                last_pop = cyc;
                model_sum += longint'(st_data[31:16]) + longint'(st_data[15:0]);
                mon_beats++;
            end
            if (error && !done) check("error_without_done", 32'(error), 32'h0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = error;
                check("busy_at_done", 32'(busy), 32'h0);
`ifdef PCP_TCM_RD_CKSUM_EN
                done_ck = cksum;
`else
                done_ck = 16'h0;
`endif
            end
            if (busy) busy_seen = 1'b1;
        end
    end

    function automatic logic [15:0] fold16(input longint s);
        longint v;
        v = s;
        while (v > 64'hFFFF) v = (v & 64'hFFFF) + (v >> 16);
        return 16'(v);
    endfunction

    typedef struct {
        int  base;
        int  len;
        int  mode;
        bit  restart;
    } xfer_t;

    task automatic clear_mon(input int b, input int l);
        tr_base = b; tr_len = l;
        mon_reads = 0; mon_beats = 0; done_cnt = 0; busy_seen = 0; model_sum = 0;
    endtask

    task automatic run_xfer(input xfer_t x);
        int  t, limit;
        bit  exp_err;
        int  exp_n;
        exp_err = (x.base + x.len > MEMD);
        exp_n   = (exp_err || x.len == 0) ? 0 : x.len;
        limit   = 20 * exp_n + 100;
        clear_mon(x.base, x.len);
        rmode = x.mode;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 13'(x.base); len_words = 14'(x.len);
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < limit) begin
            if (x.restart && t == 5) begin
                start = 1'b1; base_addr = 13'h0; len_words = 14'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL timeout base=%h len=%0d actual=no_done required=done", x.base, x.len);
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_error", 32'(done_err), 32'(exp_err));
        check("reads", 32'(mon_reads), 32'(exp_n));
        check("beats", 32'(mon_beats), 32'(exp_n));
        check("busy_seen", 32'(busy_seen), 32'(exp_n != 0));
        if (exp_n > 0) check("done_after_last_pop", 32'(done_cyc - last_pop), 32'd1);
        else           check("done_after_start", 32'(done_cyc - start_cyc), 32'd1);
        if (x.mode == 0 && exp_n > 0) begin
            check("first_valid_latency", 32'(first_pop - start_cyc), 32'd3);
            check("beat_span", 32'(last_pop - first_pop + 1), 32'(exp_n));
            check("read_span", 32'(last_cs - first_cs + 1), 32'(exp_n));
        end
`ifdef PCP_TCM_RD_CKSUM_EN
        if (exp_n > 0) check("cksum", 32'(done_ck), 32'(fold16(model_sum)));
`endif
    endtask

    xfer_t vec [10];

    initial begin
        for (int i = 0; i < MEMD; i++) mem[i] = $urandom;
        vec[0] = '{base: 'h010,  len: 4,     mode: 0, restart: 0};
        vec[1] = '{base: 'h200,  len: 16,    mode: 1, restart: 0};
        vec[2] = '{base: 'h17FF, len: 1,     mode: 0, restart: 0};
        vec[3] = '{base: 'h17FF, len: 2,     mode: 0, restart: 0};
        vec[4] = '{base: 'h050,  len: 0,     mode: 0, restart: 0};
        vec[5] = '{base: 'h300,  len: 16,    mode: 1, restart: 1};
        vec[6] = '{base: 'h1700, len: 256,   mode: 2, restart: 0};
        vec[7] = '{base: 'h1701, len: 256,   mode: 0, restart: 0};
        vec[8] = '{base: 'h0,    len: 8191,  mode: 0, restart: 0};
        vec[9] = '{base: 'h0,    len: 16383, mode: 0, restart: 0};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; len_words = '0; st_ready = 1'b1;
        clear_mon(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done_error", 32'({done, error}), 32'h0);
        check("rst_cs", 32'(m_chipselect), 32'h0);
        check("rst_addr", 32'(m_address), 32'h0);
        check("rst_stream", 32'({st_valid, st_sop, st_eop}), 32'h0);
        check("rst_data", st_data, 32'h0);
        check("const_ctl", 32'({m_write, m_byteenable, m_clken}), 32'h1F);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_xfer(vec[i]);

        for (int i = 0; i < 8; i++) begin
            xfer_t r;
            r.base = $urandom_range(0, MEMD - 1);
            r.len  = $urandom_range(1, 48);
            if ($urandom_range(0, 3) == 0) r.base = MEMD - $urandom_range(1, 40);
            r.mode = 2;
            r.restart = 0;
            run_xfer(r);
        end

        // Abort with sink stalled: credits cap reads at FIFO depth.
        clear_mon('h080, 8);
        rmode = 3;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 13'h080; len_words = 14'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 20 && !st_valid; t++) begin
            @(posedge clk); #1;
        end
        check("abort_pre_valid", 32'(st_valid), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(st_valid), 32'h0);
        check("abort_done", 32'(done), 32'h1);
        check("abort_error", 32'(error), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_reads", 32'(mon_reads), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        check("abort_done_count", 32'(done_cnt), 32'd1);
        check("abort_no_beats", 32'(mon_beats), 32'd0);
        run_xfer('{base: 'h400, len: 2, mode: 0, restart: 0});

        // Asynchronous reset in the middle of a transfer.
        clear_mon('h600, 64);
        rmode = 1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 13'h600; len_words = 14'd64;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("areset_state", 32'({busy, m_chipselect, st_valid, done}), 32'h0);
        check("areset_addr", 32'(m_address), 32'h0);
        check("areset_data", st_data, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("areset_no_done", 32'({done, 31'(done_cnt)}), 32'h0);
        reset_n = 1'b1;

`ifdef PCP_TCM_RD_CKSUM_EN
        mem['h100] = 32'hFFFF0001;
        mem['h101] = 32'h00020003;
        run_xfer('{base: 'h100, len: 2, mode: 0, restart: 0});
        check("cksum_fixed", 32'(done_ck), 32'h0006);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pcp_tcm_stream_reader
`default_nettype wire
